// File: rtl/rf_scoreboard.sv
// Read-side hazard tracker beside the ID-stage register file: counts in-flight
// writes per register and stalls ID while a source register is still pending.
module rf_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic              id_we,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic              stall,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              any_pending,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic                any_pending_q;
    logic                any_pending_d;
    logic                err_underflow_q;
    logic                err_underflow_d;

    logic [NUM_REGS-1:0] retire_vec;
    logic [NUM_REGS-1:0] issue_vec;
    logic [NUM_REGS-1:0] underflow_vec;
    logic [CNT_W-1:0]    cnt_rs1;
    logic [CNT_W-1:0]    cnt_rs2;
    logic [CNT_W-1:0]    cnt_rd;
    logic                retire_rs1;
    logic                retire_rs2;
    logic                retire_rd;
    logic                sat;
    logic                issue;

    // WB write decode; r0 is hard-wired zero in the RF so it never retires.
    always_comb begin
        retire_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            retire_vec[r] = wb_write && (wb_rd == ADDR_W'(r));
        end
    end

    always_comb begin
        cnt_rs1    = cnt_q[id_rs1];
        cnt_rs2    = cnt_q[id_rs2];
        cnt_rd     = cnt_q[id_rd];
        retire_rs1 = retire_vec[id_rs1];
        retire_rs2 = retire_vec[id_rs2];
        retire_rd  = retire_vec[id_rd];
    end

    // The RF writes on negedge, so a retiring last write is already readable.
    always_comb begin
        busy_rs1 = id_valid && id_rs1_used && (id_rs1 != '0) && (cnt_rs1 != '0)
                   && !((cnt_rs1 == CNT_ONE) && retire_rs1);
        busy_rs2 = id_valid && id_rs2_used && (id_rs2 != '0) && (cnt_rs2 != '0)
                   && !((cnt_rs2 == CNT_ONE) && retire_rs2);
        sat      = id_valid && id_we && (id_rd != '0) && (cnt_rd == CNT_MAX)
                   && !retire_rd;
        stall    = busy_rs1 | busy_rs2 | sat;
    end

    // id_valid qualifies all id_* fields; stall is the only backpressure, and
    // an instruction is accepted (its write recorded) exactly in a cycle with
    // id_valid && !stall. WB writes are never backpressured.
    always_comb begin
        issue     = id_valid && id_we && (id_rd != '0) && !stall;
        issue_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            issue_vec[r] = issue && (id_rd == ADDR_W'(r));
        end
    end

    always_comb begin
        underflow_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_vec[r] && !retire_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (retire_vec[r] && !issue_vec[r]) begin
                if (cnt_q[r] == '0) begin
                    underflow_vec[r] = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        any_pending_d = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            any_pending_d = any_pending_d | (cnt_d[r] != '0);
        end
        err_underflow_d = err_underflow_q | (|underflow_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            any_pending_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            any_pending_q   <= any_pending_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign any_pending   = any_pending_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: the driver pushes hand-computed expected
// {stall, busy_rs1, busy_rs2, any_pending, err_underflow} vectors; a negedge monitor compares.
module tb_rf_scoreboard;

    localparam int W = 5;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic       id_rs1_used;
    logic [4:0] id_rs2;
    logic       id_rs2_used;
    logic       id_we;
    logic [4:0] id_rd;
    logic       wb_write;
    logic [4:0] wb_rd;
    logic       stall;
    logic       busy_rs1;
    logic       busy_rs2;
    logic       any_pending;
    logic       err_underflow;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         mon_valid;
    int           checks;
    int           errors;

    rf_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_we(id_we), .id_rd(id_rd),
        .wb_write(wb_write), .wb_rd(wb_rd),
        .stall(stall), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .any_pending(any_pending), .err_underflow(err_underflow)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: apply one cycle of inputs shortly after posedge, queue expectation.
    task automatic cyc(input string nm, input logic v,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic we, input logic [4:0] rd,
                       input logic wbw, input logic [4:0] wbrd,
                       input logic [W-1:0] exp);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_we       = we;
        id_rd       = rd;
        wb_write    = wbw;
        wb_rd       = wbrd;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        mon_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_valid) begin
            logic [W-1:0] act;
            logic [W-1:0] exp;
            string        nm;
            act = {stall, busy_rs1, busy_rs2, any_pending, err_underflow};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor_underrun actual=%b required=<queued entry>", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s actual={stall,b1,b2,pend,err}=%b required=%b", nm, act, exp);
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; mon_valid = 1'b0;
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_we = 0; id_rd = 0; wb_write = 0; wb_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        //   name               v  rs1 u1 rs2 u2 we rd  wb wbrd  exp{s,b1,b2,p,e}
        cyc("reset_idle",      0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000);
        cyc("read_clean",      1, 5,  1, 0,  0, 0, 0,  0, 0,  5'b00000);
        cyc("issue_rd5",       1, 0,  0, 0,  0, 1, 5,  0, 0,  5'b00000);
        cyc("raw_rs1_stall",   1, 5,  1, 0,  0, 0, 0,  0, 0,  5'b11010);
        cyc("raw_rs1_hold",    1, 5,  1, 0,  0, 0, 0,  0, 0,  5'b11010);
        cyc("retire_unblocks", 1, 5,  1, 0,  0, 0, 0,  1, 5,  5'b00010);
        cyc("after_retire",    1, 5,  1, 5,  1, 0, 0,  0, 0,  5'b00000);
        cyc("issue_rd0",       1, 0,  0, 0,  0, 1, 0,  0, 0,  5'b00000);
        cyc("read_r0",         1, 0,  1, 0,  1, 0, 0,  1, 0,  5'b00000);
        cyc("r0_no_err",       0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000);
        cyc("issue7_a",        1, 0,  0, 0,  0, 1, 7,  0, 0,  5'b00000);
        cyc("issue7_b",        1, 0,  0, 0,  0, 1, 7,  0, 0,  5'b00010);
        cyc("issue7_c",        1, 0,  0, 0,  0, 1, 7,  0, 0,  5'b00010);
        cyc("sat_stall",       1, 0,  0, 0,  0, 1, 7,  0, 0,  5'b10010);
        cyc("sat_retire",      1, 0,  0, 0,  0, 1, 7,  1, 7,  5'b00010);
        cyc("sat_still3",      1, 0,  0, 0,  0, 1, 7,  0, 0,  5'b10010);
        cyc("dual_src_busy",   1, 7,  1, 7,  1, 0, 0,  0, 0,  5'b11110);
        cyc("drain7_a",        0, 0,  0, 0,  0, 0, 0,  1, 7,  5'b00010);
        cyc("drain7_b",        0, 0,  0, 0,  0, 0, 0,  1, 7,  5'b00010);
        cyc("rd_eq_src_stall", 1, 7,  1, 0,  0, 1, 7,  0, 0,  5'b11010);
        cyc("rd_eq_src_ret",   1, 7,  1, 0,  0, 1, 7,  1, 7,  5'b00010);
        cyc("rd_eq_src_cnt1",  1, 7,  1, 0,  0, 0, 0,  0, 0,  5'b11010);
        cyc("drain7_c",        0, 0,  0, 0,  0, 0, 0,  1, 7,  5'b00010);
        cyc("drain_done",      0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000);
        cyc("issue_rd9",       1, 0,  0, 0,  0, 1, 9,  0, 0,  5'b00000);
        cyc("issue_retire9",   1, 0,  0, 0,  0, 1, 9,  1, 9,  5'b00010);
        cyc("cnt9_kept",       1, 0,  0, 9,  1, 0, 0,  0, 0,  5'b10110);
        cyc("drain9",          0, 0,  0, 0,  0, 0, 0,  1, 9,  5'b00010);
        cyc("underflow_wb4",   0, 0,  0, 0,  0, 0, 0,  1, 4,  5'b00000);
        cyc("err_set",         0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00001);
        cyc("issue_rd3",       1, 0,  0, 0,  0, 1, 3,  0, 0,  5'b00001);
        cyc("issue_rd8_a",     1, 0,  0, 0,  0, 1, 8,  0, 0,  5'b00011);
        cyc("issue_rd8_b",     1, 0,  0, 0,  0, 1, 8,  0, 0,  5'b00011);
        cyc("pend_3_8",        1, 3,  1, 8,  1, 0, 0,  0, 0,  5'b11111);
        rst = 1'b1;
        cyc("rst_mid",         1, 8,  1, 0,  0, 1, 3,  1, 8,  5'b11011);
        rst = 1'b0;
        cyc("after_rst",       1, 3,  1, 8,  1, 1, 8,  0, 0,  5'b00000);
        cyc("post_rst_issue",  0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00010);
        mon_valid = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_queue actual=%0d entries left required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
